// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris step controller: probe ops, FSM states, PS/2 scan codes.
package tetris_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_LEFT   = 3'd1,
        OP_RIGHT  = 3'd2,
        OP_ROTATE = 3'd3,
        OP_DROP   = 3'd4,
        OP_SPAWN  = 3'd5
    } probe_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_COMMIT,
        ST_LOCK,
        ST_SCAN,
        ST_CLEAR,
        ST_SPAWN,
        ST_OVER
    } state_e;

    localparam logic [7:0] SC_LEFT      = 8'h6B;
    localparam logic [7:0] SC_RIGHT     = 8'h74;
    localparam logic [7:0] SC_ROTATE    = 8'h75;
    localparam logic [7:0] SC_SOFT_DROP = 8'h72;
    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXTEND    = 8'hE0;

    function automatic probe_op_e decode_make(input logic [7:0] code);
        probe_op_e op;
        case (code)
            SC_LEFT:   op = OP_LEFT;
            SC_RIGHT:  op = OP_RIGHT;
            SC_ROTATE: op = OP_ROTATE;
            SC_EXTEND: op = OP_NONE;
            default:   op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_soft_drop(input logic [7:0] code);
        return code == SC_SOFT_DROP;
    endfunction

endpackage

// File: rtl/tetris_key_latch.sv
// PS/2 make-code decoder with break-code suppression and a one-deep pending-key buffer.
// Build option SOFT_DROP_EN: make code 8'h72 raises o_soft_drop for one cycle.
module tetris_key_latch
    import tetris_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_byte_stb,
    input  logic [7:0] i_byte,
    input  logic       i_clear,
    output logic       o_valid,
    output probe_op_e  o_op,
    output logic       o_soft_drop
);

    logic      r_break;
    logic      r_valid;
    probe_op_e r_op;
    logic      w_make;
    probe_op_e w_dec;

    // A byte following F0 is the released key and must never become a command.
    assign w_make = i_byte_stb && !r_break && (i_byte != SC_BREAK);
    assign w_dec  = decode_make(i_byte);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_break <= 1'b0;
            r_valid <= 1'b0;
            r_op    <= OP_NONE;
        end else begin
            if (i_byte_stb) begin
                r_break <= !r_break && (i_byte == SC_BREAK);
            end
            // A fresh key beats a same-cycle clear so it is not lost.
            if (w_make && (w_dec != OP_NONE)) begin
                r_valid <= 1'b1;
                r_op    <= w_dec;
            end else if (i_clear) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SOFT_DROP_EN
    logic r_soft_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_soft_drop <= 1'b0;
        end else begin
            r_soft_drop <= w_make && is_soft_drop(i_byte);
        end
    end

    assign o_soft_drop = r_soft_drop;
`else
    assign o_soft_drop = 1'b0;
`endif

    assign o_valid = r_valid;
    assign o_op    = r_op;

endmodule

// File: rtl/tetris_step_ctrl.sv
// Tetris step controller: gravity timer, move/drop arbitration, probe handshake, lock/scan/clear/spawn.
// Build option SOFT_DROP_EN (in tetris_key_latch) lets key 8'h72 request an immediate drop.
module tetris_step_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAVITY_FRAMES = 30,
    parameter int ROWS           = 16
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        frame_tick,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    output logic        probe_valid,
    output logic [2:0]  probe_op,
    input  logic        probe_done,
    input  logic        probe_ok,
    output logic        commit,
    output logic        lock,
    output logic        spawn,
    output logic [3:0]  row_idx,
    input  logic        row_full,
    output logic        row_clear,
    output logic [15:0] lines_total,
    output logic        game_over,
    output logic        busy
);

    localparam int         FW       = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(GRAVITY_FRAMES - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    state_e        r_state;
    probe_op_e     r_probe_op;
    logic          r_probe_valid;
    logic          r_commit;
    logic          r_lock;
    logic          r_spawn;
    logic          r_row_clear;
    logic [3:0]    r_row_idx;
    logic [15:0]   r_lines;
    logic          r_game_over;
    logic [FW-1:0] r_frame_cnt;
    logic          r_grav_pend;

    logic          w_key_valid;
    probe_op_e     w_key_op;
    logic          w_soft_drop;
    logic          w_frame_wrap;
    logic          w_probe_fin;
    logic          w_grav_clr;
    logic          w_key_clr;

    tetris_key_latch u_key_latch (
        .i_clk       (iVGA_CLK),
        .i_rst_n     (iRST_n),
        .i_byte_stb  (ps2_key_pressed),
        .i_byte      (ps2_out),
        .i_clear     (w_key_clr),
        .o_valid     (w_key_valid),
        .o_op        (w_key_op),
        .o_soft_drop (w_soft_drop)
    );

    assign w_frame_wrap = frame_tick && (r_frame_cnt == FRAME_LAST);
    assign w_probe_fin  = (r_state == ST_PROBE) && probe_done;
    assign w_grav_clr   = w_probe_fin && (r_probe_op == OP_DROP);
    assign w_key_clr    = w_probe_fin && (r_probe_op != OP_DROP);

    // Gravity keeps counting while busy; a new request outranks a same-cycle service.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_frame_cnt <= '0;
            r_grav_pend <= 1'b0;
        end else begin
            if (frame_tick) begin
                r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + FW'(1);
            end
            if (w_frame_wrap || w_soft_drop) begin
                r_grav_pend <= 1'b1;
            end else if (w_grav_clr) begin
                r_grav_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state       <= ST_IDLE;
            r_probe_valid <= 1'b0;
            r_probe_op    <= OP_NONE;
            r_commit      <= 1'b0;
            r_lock        <= 1'b0;
            r_spawn       <= 1'b0;
            r_row_clear   <= 1'b0;
            r_row_idx     <= 4'd0;
            r_lines       <= 16'd0;
            r_game_over   <= 1'b0;
        end else begin
            r_commit    <= 1'b0;
            r_lock      <= 1'b0;
            r_spawn     <= 1'b0;
            r_row_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_grav_pend) begin
                        r_probe_op    <= OP_DROP;
                        r_probe_valid <= 1'b1;
                        r_state       <= ST_PROBE;
                    end else if (w_key_valid) begin
                        r_probe_op    <= w_key_op;
                        r_probe_valid <= 1'b1;
                        r_state       <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    if (probe_done) begin
                        r_probe_valid <= 1'b0;
                        r_probe_op    <= OP_NONE;
                        if (probe_ok) begin
                            r_commit <= 1'b1;
                            r_state  <= ST_COMMIT;
                        end else if (r_probe_op == OP_DROP) begin
                            r_lock    <= 1'b1;
                            r_row_idx <= 4'd0;
                            r_state   <= ST_LOCK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: r_state <= ST_IDLE;
                ST_LOCK:   r_state <= ST_SCAN;
                ST_SCAN: begin
                    // A cleared row pulls the rows above down, so the same index is re-checked.
                    if (row_full) begin
                        r_row_clear <= 1'b1;
                        if (r_lines != 16'hFFFF) begin
                            r_lines <= r_lines + 16'd1;
                        end
                        r_state <= ST_CLEAR;
                    end else if (r_row_idx == LAST_ROW) begin
                        r_probe_op    <= OP_SPAWN;
                        r_probe_valid <= 1'b1;
                        r_state       <= ST_SPAWN;
                    end else begin
                        r_row_idx <= r_row_idx + 4'd1;
                    end
                end
                ST_CLEAR: r_state <= ST_SCAN;
                ST_SPAWN: begin
                    if (probe_done) begin
                        r_probe_valid <= 1'b0;
                        r_probe_op    <= OP_NONE;
                        if (probe_ok) begin
                            r_spawn <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_OVER;
                        end
                    end
                end
                ST_OVER: r_state <= ST_OVER;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign probe_valid = r_probe_valid;
    assign probe_op    = r_probe_op;
    assign commit      = r_commit;
    assign lock        = r_lock;
    assign spawn       = r_spawn;
    assign row_clear   = r_row_clear;
    assign row_idx     = r_row_idx;
    assign lines_total = r_lines;
    assign game_over   = r_game_over;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tetris_step_ctrl.sv
// Directed bench for tetris_step_ctrl: gravity, key decode, arbitration, lock/scan/clear, game over, reset.
module tb_tetris_step_ctrl;
    import tetris_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_out = 8'h00;
    logic        probe_valid;
    logic [2:0]  probe_op;
    logic        probe_done = 1'b0;
    logic        probe_ok = 1'b0;
    logic        commit;
    logic        lock;
    logic        spawn;
    logic [3:0]  row_idx;
    logic        row_full = 1'b0;
    logic        row_clear;
    logic [15:0] lines_total;
    logic        game_over;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int commit_cnt = 0;
    int lock_cnt = 0;
    int spawn_cnt = 0;
    int clear_cnt = 0;
    logic [3:0] clear_row = 4'd0;
    logic [2:0] op_log[$];

    int   resp_delay = 0;
    logic ok_move = 1'b1;
    logic ok_drop = 1'b1;
    logic ok_spawn = 1'b1;
    logic row15_full = 1'b0;
    int   exp_n;

    tetris_step_ctrl #(.GRAVITY_FRAMES(2), .ROWS(16)) dut (
        .iVGA_CLK        (clk),
        .iRST_n          (rst_n),
        .frame_tick      (frame_tick),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .probe_valid     (probe_valid),
        .probe_op        (probe_op),
        .probe_done      (probe_done),
        .probe_ok        (probe_ok),
        .commit          (commit),
        .lock            (lock),
        .spawn           (spawn),
        .row_idx         (row_idx),
        .row_full        (row_full),
        .row_clear       (row_clear),
        .lines_total     (lines_total),
        .game_over       (game_over),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (commit)    commit_cnt <= commit_cnt + 1;
        if (lock)      lock_cnt   <= lock_cnt + 1;
        if (spawn)     spawn_cnt  <= spawn_cnt + 1;
        if (row_clear) begin
            clear_cnt <= clear_cnt + 1;
            clear_row <= row_idx;
        end
        if (probe_valid && probe_done) op_log.push_back(probe_op);
    end

    // Playfield model: answers probes after resp_delay cycles; row 15 full until cleared once.
    initial begin : responder
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (probe_valid && !probe_done) begin
                if (waited >= resp_delay) begin
                    probe_done = 1'b1;
                    probe_ok   = (probe_op == 3'd4) ? ok_drop :
                                 (probe_op == 3'd5) ? ok_spawn : ok_move;
                    waited     = 0;
                end else begin
                    waited++;
                end
            end else begin
                probe_done = 1'b0;
                probe_ok   = 1'b0;
                waited     = 0;
            end
            if (row_clear) row15_full = 1'b0;
            row_full = row15_full && (row_idx == 4'd15);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] log_at(input int i);
        if (i < op_log.size()) return op_log[i];
        return 3'h7;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ps2_out = b;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin : stimulus
        tick(2);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_probe_op", probe_op, 0);
        check("rst_busy", busy, 0);
        check("rst_game_over", game_over, 0);
        check("rst_lines", lines_total, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_pulses", {commit, lock, spawn, row_clear}, 0);
        rst_n = 1'b1;
        tick(2);

        // Gravity after exactly two frames
        pulse_frame();
        tick(4);
        check("grav_one_frame_no_probe", op_log.size(), 0);
        pulse_frame();
        tick(10);
        check("grav_log_size", op_log.size(), 1);
        check("grav_op", log_at(0), OP_DROP);
        check("grav_commit", commit_cnt, 1);
        check("grav_idle", busy, 0);
        $display("step gravity: probes=%0d commits=%0d", op_log.size(), commit_cnt);

        // Make then break of LEFT
        send_byte(8'h6B);
        send_byte(8'hF0);
        send_byte(8'h6B);
        tick(10);
        check("left_log_size", op_log.size(), 2);
        check("left_op", log_at(1), OP_LEFT);
        check("left_commit", commit_cnt, 2);
        $display("step left+break: probes=%0d commits=%0d", op_log.size(), commit_cnt);

        // RIGHT key lands in the cycle gravity matures
        pulse_frame();
        frame_tick = 1'b1;
        ps2_out = 8'h74;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ps2_key_pressed = 1'b0;
        tick(15);
        check("arb_log_size", op_log.size(), 4);
        check("arb_first_drop", log_at(2), OP_DROP);
        check("arb_then_right", log_at(3), OP_RIGHT);
        check("arb_commit", commit_cnt, 4);
        $display("step arbitration: ops=%0d,%0d", log_at(2), log_at(3));

        // Rejected LEFT with a slow datapath
        ok_move = 1'b0;
        resp_delay = 3;
        send_byte(8'h6B);
        tick(1);
        check("hold_probe_valid", probe_valid, 1);
        check("hold_probe_op", probe_op, OP_LEFT);
        check("hold_busy", busy, 1);
        tick(2);
        check("hold_op_stable", probe_op, OP_LEFT);
        tick(10);
        check("rej_log_size", op_log.size(), 5);
        check("rej_op", log_at(4), OP_LEFT);
        check("rej_no_commit", commit_cnt, 4);
        check("rej_idle", busy, 0);
        resp_delay = 0;
        ok_move = 1'b1;
        $display("step rejected left: probes=%0d commits=%0d", op_log.size(), commit_cnt);

        // Extended prefix alone does nothing
        send_byte(8'hE0);
        tick(5);
        check("e0_no_probe", op_log.size(), 5);

        // Rejected DROP with row 15 full once
        ok_drop = 1'b0;
        row15_full = 1'b1;
        pulse_frame();
        tick(1);
        pulse_frame();
        tick(45);
        check("lock_log_size", op_log.size(), 7);
        check("lock_drop", log_at(5), OP_DROP);
        check("lock_spawn_probe", log_at(6), OP_SPAWN);
        check("lock_pulses", lock_cnt, 1);
        check("clear_pulses", clear_cnt, 1);
        check("clear_row", clear_row, 15);
        check("lines_total", lines_total, 1);
        check("spawn_pulses", spawn_cnt, 1);
        check("lock_no_commit", commit_cnt, 4);
        check("lock_idle", busy, 0);
        $display("step lock/clear: lines=%0d clear_row=%0d spawns=%0d", lines_total, clear_row, spawn_cnt);

        // Rejected SPAWN -> game over
        ok_spawn = 1'b0;
        pulse_frame();
        tick(1);
        pulse_frame();
        tick(40);
        check("over_flag", game_over, 1);
        check("over_busy", busy, 1);
        check("over_log_size", op_log.size(), 9);
        check("over_spawn_probe", log_at(8), OP_SPAWN);
        check("over_lines", lines_total, 1);
        send_byte(8'h6B);
        pulse_frame();
        pulse_frame();
        tick(10);
        check("over_ignores_inputs", op_log.size(), 9);
        check("over_no_probe", probe_valid, 0);
        check("over_sticky", game_over, 1);
        rst_n = 1'b0;
        #1;
        check("over_rst_game_over", game_over, 0);
        check("over_rst_busy", busy, 0);
        check("over_rst_lines", lines_total, 0);
        tick(2);
        rst_n = 1'b1;
        ok_drop = 1'b1;
        ok_spawn = 1'b1;
        tick(5);
        check("rst_clears_pending", op_log.size(), 9);
        $display("step game over + reset: game_over=%0d busy=%0d", game_over, busy);

        // Soft-drop key
        send_byte(8'h72);
        tick(8);
`ifdef SOFT_DROP_EN
        exp_n = 10;
        check("soft_drop_op", log_at(9), OP_DROP);
`else
        exp_n = 9;
`endif
        check("soft_drop_log_size", op_log.size(), exp_n);
        $display("step soft drop key: probes=%0d", op_log.size());

        // Reset in the middle of a probe
        resp_delay = 20;
        pulse_frame();
        send_byte(8'h75);
        tick(2);
        check("mid_probe_valid", probe_valid, 1);
        check("mid_probe_op", probe_op, OP_ROTATE);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", probe_valid, 0);
        check("mid_rst_op", probe_op, 0);
        tick(1);
        rst_n = 1'b1;
        resp_delay = 0;
        tick(2);
        pulse_frame();
        tick(6);
        check("mid_rst_counter_cleared", op_log.size(), exp_n);
        check("mid_rst_idle", busy, 0);
        $display("step mid-probe reset: probe_valid=%0d probes=%0d", probe_valid, op_log.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
